// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit-address I2C target, oversampled by the system clock.
// Never stretches SCL; SDA is only ever pulled low or released.
//
// Ports:
//   clk      system clock (>= 8x SCL, each SCL phase >= 4 clk)
//   rst_n    asynchronous active-low reset
//   scl      I2C clock from the master
//   sda      I2C data, open-drain
//   rx_data  last received write-data byte
//   rx_valid one-clk pulse when rx_data updates
//   tx_data  byte returned on a read, sampled when tx_ack pulses
//   tx_ack   one-clk pulse when tx_data is loaded into the shifter
//   busy     high from address match until STOP or repeated START
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ack,
   output logic       busy
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ADDR      = 3'd1;
   localparam logic [2:0] ADDR_ACK  = 3'd2;
   localparam logic [2:0] RX        = 3'd3;
   localparam logic [2:0] RX_ACK    = 3'd4;
   localparam logic [2:0] TX        = 3'd5;
   localparam logic [2:0] TX_ACK    = 3'd6;
   localparam logic [2:0] WAIT_STOP = 3'd7;

   logic [2:0] scl_sync;
   logic [2:0] sda_sync;
   logic [2:0] state;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic       rw;
   logic       phase;   // ACK slots: second half of the handshake has begun
   logic       sda_oe;  // 1 = pull SDA low

   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] shift_in;

   // Bit 1 is the synchronized level, bit 2 its previous value.
   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_sync[1] & ~scl_sync[2];
   assign scl_fall  = ~scl_sync[1] & scl_sync[2];
   assign start_det = scl_s & ~sda_sync[1] & sda_sync[2];
   assign stop_det  = scl_s & sda_sync[1] & ~sda_sync[2];
   assign shift_in  = {shift[6:0], sda_s};

   assign sda = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 3'b111;
         sda_sync <= 3'b111;
         state    <= IDLE;
         bit_cnt  <= 3'd0;
         shift    <= 8'h00;
         rw       <= 1'b0;
         phase    <= 1'b0;
         sda_oe   <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         tx_ack   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         scl_sync <= {scl_sync[1:0], scl};
         sda_sync <= {sda_sync[1:0], sda};
         rx_valid <= 1'b0;
         tx_ack   <= 1'b0;
         if (stop_det) begin
            state   <= IDLE;
            busy    <= 1'b0;
            sda_oe  <= 1'b0;
            bit_cnt <= 3'd0;
            phase   <= 1'b0;
         end else if (start_det) begin
            // Also covers repeated START: any partial byte is dropped.
            state   <= ADDR;
            busy    <= 1'b0;
            sda_oe  <= 1'b0;
            bit_cnt <= 3'd0;
            phase   <= 1'b0;
         end else begin
            case (state)
               ADDR: begin
                  if (scl_rise) begin
                     shift <= shift_in;
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= 3'd0;
                        if (shift_in[7:1] == SLAVE_ADDR) begin
                           state <= ADDR_ACK;
                           busy  <= 1'b1;
                           rw    <= shift_in[0];
                        end else begin
                           state <= WAIT_STOP;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               ADDR_ACK, RX_ACK: begin
                  // First falling edge starts the ACK bit, second one ends it.
                  if (scl_fall) begin
                     if (!phase) begin
                        phase  <= 1'b1;
                        sda_oe <= 1'b1;
                     end else begin
                        phase   <= 1'b0;
                        bit_cnt <= 3'd0;
                        if (state == ADDR_ACK && rw) begin
                           shift  <= tx_data;
                           tx_ack <= 1'b1;
                           sda_oe <= ~tx_data[7];
                           state  <= TX;
                        end else begin
                           sda_oe <= 1'b0;
                           state  <= RX;
                        end
                     end
                  end
               end
               RX: begin
                  if (scl_rise) begin
                     shift <= shift_in;
                     if (bit_cnt == 3'd7) begin
                        bit_cnt  <= 3'd0;
                        rx_data  <= shift_in;
                        rx_valid <= 1'b1;
                        state    <= RX_ACK;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               TX: begin
                  // The MSB went out on entry; each falling edge advances one bit.
                  if (scl_fall) begin
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= 3'd0;
                        sda_oe  <= 1'b0;
                        state   <= TX_ACK;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= {shift[6:0], 1'b0};
                        sda_oe  <= ~shift[6];
                     end
                  end
               end
               TX_ACK: begin
                  if (scl_rise) begin
                     if (sda_s) begin
                        state <= WAIT_STOP;
                     end else begin
                        phase <= 1'b1;
                     end
                  end else if (scl_fall && phase) begin
                     phase  <= 1'b0;
                     shift  <= tx_data;
                     tx_ack <= 1'b1;
                     sda_oe <= ~tx_data[7];
                     state  <= TX;
                  end
               end
               default: ;  // IDLE, WAIT_STOP: only START/STOP matter
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: drives a behavioural I2C master against i2c_slave and checks
// ACKs, received bytes, returned bytes and strobe counts against expectations
// derived from the bus address and the byte lists of each transfer.
module tb_i2c_slave;

   localparam logic [6:0] MY_ADDR = 7'h2A;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       scl = 1'b1;
   logic       m_oe = 1'b0;  // master pulls SDA low
   wire        sda_bus;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       rx_valid;
   logic       tx_ack;
   logic       busy;

   pullup (sda_bus);
   assign sda_bus = m_oe ? 1'b0 : 1'bz;

   int checks = 0;
   int errors = 0;
   int rx_pulses = 0;
   int tx_pulses = 0;
   int slave_low = 0;
   int overlap = 0;
   int stray = 0;
   int tx_base = 0;
   logic [7:0] rx_log[$];
   logic [7:0] tx_bytes[4];
   logic [1:0] tx_sel;

   // Next byte to offer is the one after the number already taken.
   assign tx_sel  = 2'(tx_pulses - tx_base);
   assign tx_data = tx_bytes[tx_sel];

   always #5 clk = ~clk;

   i2c_slave #(.SLAVE_ADDR(MY_ADDR)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl      (scl),
      .sda      (sda_bus),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_ack   (tx_ack),
      .busy     (busy)
   );

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_pulses++;
         rx_log.push_back(rx_data);
      end
      if (tx_ack) tx_pulses++;
      if (rx_valid && tx_ack) overlap++;
      if ((rx_valid || tx_ack) && !busy) stray++;
      if (!m_oe && sda_bus === 1'b0) slave_low++;
   end

   // ---------------- master model ----------------
   task automatic clock_bit(input logic b, output logic r);
      m_oe = ~b;
      #40 scl = 1'b1;
      #40 r = sda_bus;
      #40 scl = 1'b0;
      #40;
   endtask

   task automatic start_cond();
      m_oe = 1'b0;
      #40 scl = 1'b1;
      #40 m_oe = 1'b1;
      #40 scl = 1'b0;
      #40;
   endtask

   task automatic stop_cond();
      m_oe = 1'b1;
      #40 scl = 1'b1;
      #40 m_oe = 1'b0;
      #80;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
      clock_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic r;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         clock_bit(1'b1, r);
         d = {d[6:0], r};
      end
      clock_bit(nack, r);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", sda_bus); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
      checks++; if (tx_ack !== 1'b0) begin errors++; $display("FAIL reset_tx_ack got %b exp 0", tx_ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_write_single();
      logic a0, a1;
      int base = rx_log.size();
      start_cond();
      send_byte({MY_ADDR, 1'b0}, a0);
      checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL wr1_addr_ack got %b exp 1", a0); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr1_busy got %b exp 1", busy); end
      send_byte(8'hB3, a1);
      checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL wr1_data_ack got %b exp 1", a1); end
      stop_cond();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr1_busy_after_stop got %b exp 0", busy); end
      checks++; if (rx_log.size() - base != 1) begin errors++; $display("FAIL wr1_rx_count got %0d exp 1", rx_log.size() - base); end
      else begin
         checks++; if (rx_log[base] !== 8'hB3) begin errors++; $display("FAIL wr1_rx_data got %h exp b3", rx_log[base]); end
      end
   endtask

   task automatic test_wrong_addr();
      logic a0, a1;
      int base = rx_log.size();
      int low0 = slave_low;
      start_cond();
      send_byte({7'h15, 1'b0}, a0);
      checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack got %b exp 0", a0); end
      send_byte(8'hFF, a1);
      checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL wrong_data_ack got %b exp 0", a1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrong_busy got %b exp 0", busy); end
      stop_cond();
      checks++; if (slave_low != low0) begin errors++; $display("FAIL wrong_drive got %0d exp %0d", slave_low, low0); end
      checks++; if (rx_log.size() != base) begin errors++; $display("FAIL wrong_rx_count got %0d exp %0d", rx_log.size(), base); end
   endtask

   task automatic test_multi_write();
      logic [7:0] data [3] = '{8'h11, 8'h22, 8'h33};
      logic a;
      int base = rx_log.size();
      start_cond();
      send_byte({MY_ADDR, 1'b0}, a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL mw_addr_ack got %b exp 1", a); end
      for (int i = 0; i < 3; i++) begin
         send_byte(data[i], a);
         checks++; if (a !== 1'b1) begin errors++; $display("FAIL mw_data_ack%0d got %b exp 1", i, a); end
      end
      stop_cond();
      checks++; if (rx_log.size() - base != 3) begin errors++; $display("FAIL mw_rx_count got %0d exp 3", rx_log.size() - base); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_log[base + i] !== data[i]) begin
               errors++; $display("FAIL mw_rx_data%0d got %h exp %h", i, rx_log[base + i], data[i]);
            end
         end
      end
   endtask

   task automatic test_read(input int n, input logic [7:0] b0, input logic [7:0] b1);
      logic a;
      logic [7:0] d;
      logic [7:0] exp_b [2];
      int low0;
      exp_b[0] = b0; exp_b[1] = b1;
      tx_bytes[0] = b0; tx_bytes[1] = b1; tx_bytes[2] = 8'h00; tx_bytes[3] = 8'h00;
      tx_base = tx_pulses;
      start_cond();
      send_byte({MY_ADDR, 1'b1}, a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_addr_ack got %b exp 1", a); end
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, d);
         checks++; if (d !== exp_b[i]) begin errors++; $display("FAIL rd_byte%0d got %h exp %h", i, d, exp_b[i]); end
      end
      low0 = slave_low;
      checks++; if (tx_pulses - tx_base != n) begin errors++; $display("FAIL rd_tx_ack_count got %0d exp %0d", tx_pulses - tx_base, n); end
      stop_cond();
      checks++; if (slave_low != low0) begin errors++; $display("FAIL rd_drive_after_nack got %0d exp %0d", slave_low, low0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop got %b exp 0", busy); end
   endtask

   task automatic test_repeated_start();
      logic a, r;
      logic [7:0] partial = 8'($urandom);
      logic [7:0] d;
      logic [7:0] tb = 8'($urandom);
      int base = rx_log.size();
      tx_bytes[0] = tb;
      tx_base = tx_pulses;
      start_cond();
      send_byte({MY_ADDR, 1'b0}, a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL rs_first_ack got %b exp 1", a); end
      for (int i = 7; i >= 4; i--) clock_bit(partial[i], r);
      start_cond();
      send_byte({MY_ADDR, 1'b1}, a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL rs_second_ack got %b exp 1", a); end
      recv_byte(1'b1, d);
      checks++; if (d !== tb) begin errors++; $display("FAIL rs_read got %h exp %h", d, tb); end
      stop_cond();
      checks++; if (rx_log.size() != base) begin errors++; $display("FAIL rs_rx_count got %0d exp %0d", rx_log.size(), base); end
      checks++; if (tx_pulses - tx_base != 1) begin errors++; $display("FAIL rs_tx_ack got %0d exp 1", tx_pulses - tx_base); end
   endtask

   task automatic test_reset_in_ack();
      logic r;
      logic [7:0] ab = {MY_ADDR, 1'b0};
      start_cond();
      for (int i = 7; i >= 0; i--) clock_bit(ab[i], r);
      m_oe = 1'b0;
      #1;
      checks++; if (sda_bus !== 1'b0) begin errors++; $display("FAIL rst_ack_pre_drive got %b exp 0", sda_bus); end
      rst_n = 1'b0;
      #1;
      checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL rst_ack_sda got %b exp 1", sda_bus); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_ack_busy got %b exp 0", busy); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_ack_rx_data got %h exp 00", rx_data); end
      checks++; if ({rx_valid, tx_ack} !== 2'b00) begin errors++; $display("FAIL rst_ack_strobes got %b exp 00", {rx_valid, tx_ack}); end
      #38 scl = 1'b1;
      #50 rst_n = 1'b1;
      #50;
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         logic [6:0] addr;
         logic rw, a, match;
         int n, base;
         logic [7:0] bytes [3];
         logic [7:0] d;
         addr  = ($urandom_range(0, 2) != 0) ? MY_ADDR : 7'($urandom);
         rw    = 1'($urandom);
         n     = $urandom_range(1, 3);
         match = (addr == MY_ADDR);
         for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
         base = rx_log.size();
         for (int i = 0; i < 3; i++) tx_bytes[i] = bytes[i];
         tx_bytes[3] = 8'h00;
         tx_base = tx_pulses;
         start_cond();
         send_byte({addr, rw}, a);
         checks++; if (a !== match) begin errors++; $display("FAIL rnd%0d_addr_ack got %b exp %b", t, a, match); end
         if (match && !rw) begin
            for (int i = 0; i < n; i++) begin
               send_byte(bytes[i], a);
               checks++; if (a !== 1'b1) begin errors++; $display("FAIL rnd%0d_wr_ack%0d got %b exp 1", t, i, a); end
            end
         end else if (match) begin
            for (int i = 0; i < n; i++) begin
               recv_byte(i == n - 1, d);
               checks++; if (d !== bytes[i]) begin errors++; $display("FAIL rnd%0d_rd%0d got %h exp %h", t, i, d, bytes[i]); end
            end
         end
         stop_cond();
         checks++;
         if (rx_log.size() - base != ((match && !rw) ? n : 0)) begin
            errors++; $display("FAIL rnd%0d_rx_count got %0d exp %0d", t, rx_log.size() - base, (match && !rw) ? n : 0);
         end else if (match && !rw) begin
            for (int i = 0; i < n; i++) begin
               checks++;
               if (rx_log[base + i] !== bytes[i]) begin
                  errors++; $display("FAIL rnd%0d_rx%0d got %h exp %h", t, i, rx_log[base + i], bytes[i]);
               end
            end
         end
         checks++;
         if (tx_pulses - tx_base != ((match && rw) ? n : 0)) begin
            errors++; $display("FAIL rnd%0d_tx_count got %0d exp %0d", t, tx_pulses - tx_base, (match && rw) ? n : 0);
         end
      end
   endtask

   initial begin
      tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00; tx_bytes[3] = 8'h00;
      test_reset();
      test_write_single();
      test_wrong_addr();
      test_multi_write();
      test_read(1, 8'h5C, 8'h00);
      test_read(2, 8'hA5, 8'h3C);
      test_repeated_start();
      test_reset_in_ack();
      test_random();
      checks++; if (overlap != 0) begin errors++; $display("FAIL strobe_overlap got %0d exp 0", overlap); end
      checks++; if (stray != 0) begin errors++; $display("FAIL strobe_unaddressed got %0d exp 0", stray); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
